// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The optional misaligned-redirect trap is enabled by INST_FETCH_MISALIGN_EN.
package inst_fetch_pkg;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } fetch_state_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Memory, redirect and decoder-side handshake bundle for inst_fetch.
interface inst_fetch_if;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  modport master (
    output mem_req_valid, mem_req_addr, out_valid, out_pc, out_inst,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, out_valid, out_pc, out_inst,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/inst_fetch_fifo.sv
// Two-entry shift FIFO of fetched {pc, inst}; the head is a register so it
// drives the decoder outputs directly. Flush wins over push and pop.
module fetch_fifo
  import inst_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t din_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   count_q, count_d;
  logic         do_pop_s;

  assign do_pop_s = pop_i && (count_q != 2'd0);

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_i, do_pop_s})
        2'b10: begin
          if (count_q == 2'd0) begin
            e0_d    = din_i;
            count_d = 2'd1;
          end else if (count_q == 2'd1) begin
            e1_d    = din_i;
            count_d = 2'd2;
          end else begin
            count_d = count_q;
          end
        end
        2'b01: begin
          e0_d    = e1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            e0_d = din_i;
          end else begin
            e0_d = e1_q;
            e1_d = din_i;
          end
        end
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q    <= 64'd0;
      e1_q    <= 64'd0;
      count_q <= 2'd0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
    end
  end

  assign head_o  = e0_q;
  assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: single-outstanding request FSM feeding a 2-entry buffer.
// Define INST_FETCH_MISALIGN_EN to trap misaligned redirects (misalign_err).
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  inst_fetch_if.master bus
`ifdef INST_FETCH_MISALIGN_EN
  ,
  output logic         misalign_err
`endif
);

  logic [1:0]   state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         outstanding_q, outstanding_d;
  logic         drop_q, drop_d;
  logic         misalign_q, misalign_d;

  logic [1:0]   fifo_cnt_s;
  fetch_entry_t head_s, entry_s;
  logic         req_valid_s, accept_s, rsp_s, push_s, pop_s, out_valid_s;
  logic         slot_free_s, bad_rdr_s;
  logic [31:0]  rdr_pc_s;

`ifdef INST_FETCH_MISALIGN_EN
  assign rdr_pc_s  = bus.redirect_pc & ~32'h0000_0003;
  assign bad_rdr_s = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  assign misalign_err = misalign_q;
`else
  assign rdr_pc_s  = bus.redirect_pc & ~32'h0000_0003;
  assign bad_rdr_s = 1'b0;
`endif

  assign req_valid_s = (state_q == ST_REQ) && !outstanding_q &&
                       ((fifo_cnt_s + {1'b0, outstanding_q}) < 2'd2);
  assign accept_s    = req_valid_s && bus.mem_req_ready;
  assign rsp_s       = bus.mem_rsp_valid && outstanding_q;
  assign out_valid_s = (fifo_cnt_s != 2'd0);
  assign pop_s       = out_valid_s && bus.out_ready;
  // Responses for a redirected-away request, or racing a redirect, are dropped.
  assign push_s      = rsp_s && !drop_q && !bus.redirect_valid;
  assign slot_free_s = (fifo_cnt_s == 2'd0) || ((fifo_cnt_s == 2'd1) && pop_s);

  assign entry_s.pc   = req_pc_q;
  assign entry_s.inst = bus.mem_rsp_data;

  always_comb begin
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    misalign_d    = misalign_q;
    state_d       = state_q;
    if (accept_s) begin
      pc_d          = next_pc(pc_q);
      req_pc_d      = pc_q;
      outstanding_d = 1'b1;
    end else if (rsp_s) begin
      outstanding_d = 1'b0;
    end else begin
      outstanding_d = outstanding_q;
    end
    if (bus.redirect_valid) begin
      pc_d       = rdr_pc_s;
      drop_d     = (outstanding_q && !rsp_s) || accept_s;
      misalign_d = misalign_q || bad_rdr_s;
      state_d    = (misalign_q || bad_rdr_s) ? ST_IDLE : ST_REQ;
    end else begin
      drop_d = rsp_s ? 1'b0 : drop_q;
      case (state_q)
        ST_IDLE: state_d = misalign_q ? ST_IDLE : ST_REQ;
        ST_REQ:  state_d = accept_s ? ST_WAIT : ST_REQ;
        ST_WAIT: begin
          if (rsp_s) begin
            state_d = slot_free_s ? ST_REQ : ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      req_pc_q      <= 32'd0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      misalign_q    <= misalign_d;
    end
  end

  fetch_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (bus.redirect_valid),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .din_i   (entry_s),
    .head_o  (head_s),
    .count_o (fifo_cnt_s)
  );

  assign bus.mem_req_valid = req_valid_s;
  assign bus.mem_req_addr  = pc_q;
  assign bus.out_valid     = out_valid_s;
  assign bus.out_pc        = head_s.pc;
  assign bus.out_inst      = head_s.inst;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a latency-programmable memory model and
// an in-order delivery scoreboard. Honors INST_FETCH_MISALIGN_EN.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  inst_fetch_if bus_if();
`ifdef INST_FETCH_MISALIGN_EN
  logic misalign_err;
`endif

  inst_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
`ifdef INST_FETCH_MISALIGN_EN
    ,
    .misalign_err (misalign_err)
`endif
  );

  always #5 clk = ~clk;

  int          err_cnt = 0;
  int          chk_cnt = 0;
  int          mem_lat = 1;
  int          del_cnt = 0;
  logic [31:0] exp_pc  = RESET_PC;
  logic [31:0] acc_q[$];
  logic        pend;
  int          wait_cnt;
  logic [31:0] pend_addr;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h00A0_0113;
    else return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = tgt;
    tick(1);
    bus_if.redirect_valid = 1'b0;
  endtask

  // Memory model, accept logger and delivery scoreboard, all mid-cycle.
  initial begin
    pend = 1'b0;
    wait_cnt = 0;
    pend_addr = 32'd0;
    bus_if.mem_rsp_valid = 1'b0;
    bus_if.mem_rsp_data  = 32'd0;
    forever begin
      @(negedge clk);
      bus_if.mem_rsp_valid = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (wait_cnt == 0) begin
            bus_if.mem_rsp_valid = 1'b1;
            bus_if.mem_rsp_data  = inst_of(pend_addr);
            pend = 1'b0;
          end else begin
            wait_cnt--;
          end
        end
        if (bus_if.mem_req_valid && bus_if.mem_req_ready) begin
          pend      = 1'b1;
          pend_addr = bus_if.mem_req_addr;
          wait_cnt  = mem_lat - 1;
          acc_q.push_back(bus_if.mem_req_addr);
        end
        if (bus_if.out_valid && bus_if.out_ready) begin
          check_eq("deliv_pc", bus_if.out_pc, exp_pc);
          check_eq("deliv_inst", bus_if.out_inst, inst_of(exp_pc));
          exp_pc = exp_pc + 32'd4;
          del_cnt++;
        end
        if (bus_if.redirect_valid) exp_pc = {bus_if.redirect_pc[31:2], 2'b00};
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic found;
    rst_n = 1'b0;
    bus_if.mem_req_ready  = 1'b1;
    bus_if.out_ready      = 1'b1;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = 32'd0;
    tick(3);
    check_eq("rst_req_valid", bus_if.mem_req_valid, 32'd0);
    check_eq("rst_out_valid", bus_if.out_valid, 32'd0);
    check_eq("rst_out_pc", bus_if.out_pc, 32'd0);
    check_eq("rst_out_inst", bus_if.out_inst, 32'd0);
`ifdef INST_FETCH_MISALIGN_EN
    check_eq("rst_misalign", misalign_err, 32'd0);
`endif
    rst_n = 1'b1;
    check_eq("idle_no_req", bus_if.mem_req_valid, 32'd0);
    tick(1);
    check_eq("first_req_valid", bus_if.mem_req_valid, 32'd1);
    check_eq("first_req_addr", bus_if.mem_req_addr, 32'h8000_0000);
    tick(1);
    check_eq("wait_no_req", bus_if.mem_req_valid, 32'd0);
    tick(1);
    check_eq("first_out_valid", bus_if.out_valid, 32'd1);
    check_eq("first_out_pc", bus_if.out_pc, 32'h8000_0000);
    check_eq("first_out_inst", bus_if.out_inst, 32'h00A0_0113);
    tick(12);
    check_eq("acc0", acc_q[0], 32'h8000_0000);
    check_eq("acc1", acc_q[1], 32'h8000_0004);
    check_eq("acc2", acc_q[2], 32'h8000_0008);
    check_eq("del_ge3", 32'(del_cnt >= 3), 32'd1);

    // Decoder stall: buffer fills, fetch stops, head holds.
    bus_if.out_ready = 1'b0;
    tick(10);
    check_eq("full_out_valid", bus_if.out_valid, 32'd1);
    check_eq("full_no_req", bus_if.mem_req_valid, 32'd0);
    check_eq("full_head_pc", bus_if.out_pc, exp_pc);
    check_eq("full_head_inst", bus_if.out_inst, inst_of(exp_pc));
    check_eq("full_depth", 32'(acc_q.size() - del_cnt), 32'd2);
    check_eq("full_last_acc", acc_q[acc_q.size() - 1], exp_pc + 32'd4);
    n0 = del_cnt;
    bus_if.out_ready = 1'b1;
    tick(12);
    check_eq("drain_resume", 32'(del_cnt - n0 >= 4), 32'd1);

    // Redirect while a request is outstanding.
    mem_lat = 3;
    redirect(32'h8000_0000);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (bus_if.mem_req_valid && bus_if.mem_req_ready &&
          bus_if.mem_req_addr == 32'h8000_0008) found = 1'b1;
      else tick(1);
    end
    check_eq("wait_acc_08", found, 32'd1);
    tick(1);
    redirect(32'h8000_0100);
    check_eq("flush_out_valid", bus_if.out_valid, 32'd0);
    n0 = del_cnt;
    tick(25);
    check_eq("after_drop_del", 32'(del_cnt > n0), 32'd1);

    // Memory back-pressure holds the request address.
    mem_lat = 1;
    bus_if.mem_req_ready = 1'b0;
    redirect(32'h8000_0200);
    tick(3);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", bus_if.mem_req_valid, 32'd1);
      check_eq("bp_addr", bus_if.mem_req_addr, 32'h8000_0200);
      tick(1);
    end
    n0 = acc_q.size();
    bus_if.mem_req_ready = 1'b1;
    tick(1);
    bus_if.mem_req_ready = 1'b0;
    check_eq("bp_single_acc", 32'(acc_q.size() - n0), 32'd1);
    tick(3);
    check_eq("bp_next_valid", bus_if.mem_req_valid, 32'd1);
    check_eq("bp_next_addr", bus_if.mem_req_addr, 32'h8000_0204);
    check_eq("bp_no_extra", 32'(acc_q.size() - n0), 32'd1);

    // PC wrap.
    redirect(32'hFFFF_FFFC);
    n0 = acc_q.size();
    bus_if.mem_req_ready = 1'b1;
    tick(8);
    check_eq("wrap_acc0", acc_q[n0], 32'hFFFF_FFFC);
    check_eq("wrap_acc1", acc_q[n0 + 1], 32'h0000_0000);

    // Misaligned redirect.
    bus_if.mem_req_ready = 1'b0;
    redirect(32'h8000_0102);
    check_eq("mis_flush", bus_if.out_valid, 32'd0);
    n0 = acc_q.size();
    bus_if.mem_req_ready = 1'b1;
    tick(10);
`ifdef INST_FETCH_MISALIGN_EN
    check_eq("mis_err", misalign_err, 32'd1);
    check_eq("mis_no_acc", 32'(acc_q.size() - n0), 32'd0);
    check_eq("mis_no_req", bus_if.mem_req_valid, 32'd0);
    check_eq("mis_no_out", bus_if.out_valid, 32'd0);
`else
    check_eq("mis_acc0", acc_q[n0], 32'h8000_0100);
    check_eq("mis_acc1", acc_q[n0 + 1], 32'h8000_0104);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 RESET_PC, 32'h8000_0000, address of the first fetch after reset.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 mem_req_valid / mem_req_ready / mem_req_addr  out/in/out  1/1/32  instruction-memory request channel.
REQ-005 mem_rsp_valid / mem_rsp_data  input  1/32  memory response, in request order, never back-pressured.
REQ-006 redirect_valid / redirect_pc  input  1/32  control-flow redirect from execute (branch/jump target).
REQ-007 out_valid / out_ready  out/in  1/1  instruction handshake to decoder.
REQ-008 out_pc / out_inst  output  32/32  PC and instruction word of the head entry.
REQ-009 misalign_err  output  1  sticky misaligned-redirect flag (present only with INST_FETCH_MISALIGN_EN).

Function
REQ-010 The block SHALL hold fetch PC `pc`, advancing by 4 on each accepted request (mem_req_valid & mem_req_ready), with 32-bit wrap from FFFF_FFFC to 0000_0000.
REQ-011 The FSM SHALL have states IDLE, REQ and WAIT: IDLE->REQ unconditionally; REQ->WAIT on request accept; WAIT->REQ on mem_rsp_valid when a buffer slot is free, else WAIT->IDLE.
REQ-012 At most one request SHALL be outstanding; mem_req_valid=1 only in REQ and only when (fifo_count + outstanding) < 2.
REQ-013 mem_req_addr SHALL equal `pc` and remain stable while mem_req_valid=1 and mem_req_ready=0.
REQ-014 Responses SHALL enter a 2-entry FIFO of {pc, inst}; out_* SHALL present the head, registered, so an instruction is visible the cycle after mem_rsp_valid.
REQ-015 out_valid SHALL be 1 iff the FIFO is non-empty; the head pops on out_valid & out_ready; push and pop in the same cycle with count 2 SHALL be legal.
REQ-016 out_pc/out_inst SHALL hold stable while out_valid=1 and out_ready=0.
REQ-017 On redirect_valid the block SHALL, in the same edge, flush the FIFO, load pc<=redirect_pc, and go to REQ; out_valid SHALL be 0 the following cycle.
REQ-018 A redirect while a request is outstanding, or coincident with a request accept, SHALL set drop_pending; the matching response SHALL be discarded and the FSM SHALL enter REQ without waiting for a free slot.
REQ-019 A redirect coincident with an out handshake SHALL complete that handshake and then flush; a redirect coincident with mem_rsp_valid SHALL discard that response.
REQ-020 Back-to-back redirects SHALL take the last target; only one drop_pending is needed given REQ-012.

Reset
REQ-021 While rst_n=0: pc=RESET_PC, state=IDLE, FIFO empty, drop_pending=0, outstanding=0, mem_req_valid=0, out_valid=0, out_pc=0, out_inst=0, misalign_err=0.
REQ-022 The first request SHALL issue in the second cycle after rst_n deasserts; reset mid-transaction SHALL abandon the outstanding request, the memory being reset with the block.

Configuration
REQ-023 With INST_FETCH_MISALIGN_EN defined, a redirect with redirect_pc[1:0]!=0 SHALL set misalign_err (sticky until reset), flush, and halt fetch in IDLE; without it the port is absent and redirect_pc[1:0] are forced to 0.

Structure
REQ-024 A shared package SHALL hold the FSM state enum, RESET_PC default, and the fetch-entry struct {pc[31:0], inst[31:0]}.
REQ-025 The 2-entry FIFO SHALL be a sub-module fetch_fifo (depth 2, flush input, count output).

Verification
REQ-026 Reset release, mem_req_ready=1, 1-cycle memory -> requests at 8000_0000, 8000_0004, 8000_0008; out_pc follows with out_inst=00A0_0113 at 8000_0000.
REQ-027 out_ready=0 for 10 cycles -> FIFO fills to 2, mem_req_valid drops, out_* stable; out_ready=1 -> in-order drain, fetch resumes at the next PC.
REQ-028 Redirect to 8000_0100 while a request to 8000_0008 is outstanding -> response dropped, next out_pc=8000_0100, no 8000_0008 delivered.
REQ-029 mem_req_ready=0 for 5 cycles -> mem_req_addr stable, single accept, pc advances by exactly 4.
REQ-030 Redirect to 8000_0102 with INST_FETCH_MISALIGN_EN -> misalign_err=1, no further requests; without the macro -> fetch at 8000_0100.
REQ-031 Start at pc=FFFF_FFFC -> next request address 0000_0000.
